// File: rtl/lcd8080_pkg.sv
// Shared definitions for the 8080-style display bus master.
// Holds the request op encodings and the bus-cycle FSM state type.
package lcd8080_pkg;

  localparam logic [1:0] OP_WR_CMD   = 2'b00;
  localparam logic [1:0] OP_WR_DATA  = 2'b01;
  localparam logic [1:0] OP_RD_DATA  = 2'b10;
  localparam logic [1:0] OP_HW_RESET = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HIGH,
    ST_RST_LOW,
    ST_RST_WAIT
  } state_t;

endpackage

// File: rtl/lcd8080_bus_master.sv
// Initiator for the 8-bit 8080-style parallel display bus.
// Turns byte requests from a valid/ready port into timed bus cycles:
// command write, data write, data read and a panel hardware-reset pulse.
//
// Ports:
//   clk, nreset            clock, synchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_op, req_data       operation code and write byte
//   rsp_valid, rsp_data    one-cycle read strobe, last byte read (held)
//   busy                   inverse of req_ready
//   lcd_reset_o            panel reset, active low
//   lcd_cs_o/dc_o/wr_o/rd_o bus control pins (cs/wr/rd active low)
//   lcd_data_o, lcd_data_oe pad drive value and drive enable
//   lcd_data_i             pad input value
//
// Every pin is a flop output. The bidirectional pad cell is driven from
// the lcd_data_o / lcd_data_oe pair, so no request input reaches a pin
// without passing through a register first.
module lcd8080_bus_master
  import lcd8080_pkg::*;
#(
  parameter int SETUP_CYCLES      = 1,
  parameter int WR_LOW_CYCLES     = 2,
  parameter int RD_LOW_CYCLES     = 4,
  parameter int HIGH_CYCLES       = 2,
  parameter int RESET_CYCLES      = 16,
  parameter int RESET_WAIT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       lcd_reset_o,
  output logic       lcd_cs_o,
  output logic       lcd_dc_o,
  output logic       lcd_wr_o,
  output logic       lcd_rd_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_data_i
);

  localparam int M0   = (SETUP_CYCLES > WR_LOW_CYCLES) ? SETUP_CYCLES : WR_LOW_CYCLES;
  localparam int M1   = (M0 > RD_LOW_CYCLES) ? M0 : RD_LOW_CYCLES;
  localparam int M2   = (M1 > HIGH_CYCLES) ? M1 : HIGH_CYCLES;
  localparam int M3   = (M2 > RESET_CYCLES) ? M2 : RESET_CYCLES;
  localparam int MAXP = (M3 > RESET_WAIT_CYCLES) ? M3 : RESET_WAIT_CYCLES;
  localparam int CW   = $clog2(MAXP) + 1;

  if (SETUP_CYCLES < 1 || WR_LOW_CYCLES < 1 || RD_LOW_CYCLES < 1 ||
      HIGH_CYCLES < 1 || RESET_CYCLES < 1 || RESET_WAIT_CYCLES < 1) begin : g_bad_param
    $error("lcd8080_bus_master: every timing parameter must be at least 1");
  end

  // Counter load value: a phase of N cycles counts N-1 down to 0.
  function automatic logic [CW-1:0] ld(input int n);
    return CW'(n - 1);
  endfunction

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_rd;   // captured at accept; selects rd vs wr strobe

  assign busy = ~req_ready;

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      is_rd       <= 1'b0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      lcd_reset_o <= 1'b1;
      lcd_cs_o    <= 1'b1;
      lcd_dc_o    <= 1'b1;
      lcd_wr_o    <= 1'b1;
      lcd_rd_o    <= 1'b1;
      lcd_data_o  <= '0;
      lcd_data_oe <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Ready comes up one cycle after reset release; otherwise it is
          // already high here because the closing phase raised it.
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            if (req_op == OP_HW_RESET) begin
              state       <= ST_RST_LOW;
              cnt         <= ld(RESET_CYCLES);
              lcd_reset_o <= 1'b0;
            end else begin
              state    <= ST_SETUP;
              cnt      <= ld(SETUP_CYCLES);
              is_rd    <= (req_op == OP_RD_DATA);
              lcd_cs_o <= 1'b0;
              // Reads address the data register, so dc is 1 for op 10 too.
              lcd_dc_o <= (req_op != OP_WR_CMD);
              if (req_op == OP_RD_DATA) begin
                lcd_data_oe <= 1'b0;
              end else begin
                lcd_data_o  <= req_data;
                lcd_data_oe <= 1'b1;
              end
            end
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            state <= ST_STROBE;
            if (is_rd) begin
              cnt      <= ld(RD_LOW_CYCLES);
              lcd_rd_o <= 1'b0;
            end else begin
              cnt      <= ld(WR_LOW_CYCLES);
              lcd_wr_o <= 1'b0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_STROBE: begin
          if (cnt == '0) begin
            state    <= ST_HIGH;
            cnt      <= ld(HIGH_CYCLES);
            lcd_wr_o <= 1'b1;
            lcd_rd_o <= 1'b1;
            // Sample at the same edge that releases rd, so the panel still
            // drives the bus when the byte is taken.
            if (is_rd) begin
              rsp_data  <= lcd_data_i;
              rsp_valid <= 1'b1;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_HIGH: begin
          if (cnt == '0) begin
            state       <= ST_IDLE;
            lcd_cs_o    <= 1'b1;
            lcd_data_oe <= 1'b0;
            req_ready   <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RST_LOW: begin
          if (cnt == '0) begin
            state       <= ST_RST_WAIT;
            cnt         <= ld(RESET_WAIT_CYCLES);
            lcd_reset_o <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        ST_RST_WAIT: begin
          if (cnt == '0) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd8080_bus_master.sv
// Bench for lcd8080_bus_master: directed steps plus random ops, each
// checked cycle by cycle against a timeline computed from the phase
// lengths, a wr-rising-edge bus viewer, and a minimum-timing instance.
module tb_lcd8080_bus_master;
  import lcd8080_pkg::*;

  localparam int S = 1, WL = 2, RL = 4, H = 2, RC = 16, RW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nreset, req_valid, req_ready, rsp_valid, busy;
  logic [1:0] req_op;
  logic [7:0] req_data, rsp_data, lcd_data_o, lcd_data_i;
  logic       lcd_reset_o, lcd_cs_o, lcd_dc_o, lcd_wr_o, lcd_rd_o, lcd_data_oe;

  lcd8080_bus_master dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .lcd_reset_o(lcd_reset_o), .lcd_cs_o(lcd_cs_o), .lcd_dc_o(lcd_dc_o),
    .lcd_wr_o(lcd_wr_o), .lcd_rd_o(lcd_rd_o), .lcd_data_o(lcd_data_o),
    .lcd_data_oe(lcd_data_oe), .lcd_data_i(lcd_data_i)
  );

  // Minimum-timing instance
  logic       m_req_valid, m_req_ready, m_rsp_valid, m_busy;
  logic [1:0] m_req_op;
  logic [7:0] m_req_data, m_rsp_data, m_data_o, m_data_i;
  logic       m_rst_o, m_cs, m_dc, m_wr, m_rd, m_oe;

  lcd8080_bus_master #(
    .SETUP_CYCLES(1), .WR_LOW_CYCLES(1), .RD_LOW_CYCLES(1), .HIGH_CYCLES(1),
    .RESET_CYCLES(1), .RESET_WAIT_CYCLES(1)
  ) dut_min (
    .clk(clk), .nreset(nreset), .req_valid(m_req_valid), .req_ready(m_req_ready),
    .req_op(m_req_op), .req_data(m_req_data), .rsp_valid(m_rsp_valid), .rsp_data(m_rsp_data),
    .busy(m_busy), .lcd_reset_o(m_rst_o), .lcd_cs_o(m_cs), .lcd_dc_o(m_dc),
    .lcd_wr_o(m_wr), .lcd_rd_o(m_rd), .lcd_data_o(m_data_o),
    .lcd_data_oe(m_oe), .lcd_data_i(m_data_i)
  );

  int n_asrt = 0;
  int n_fail = 0;

  logic [8:0] exp_q[$];   // {dc, data} the panel should latch
  logic [8:0] cap_q[$];   // what the viewer saw
  logic       wr_prev = 1'b1;

  // Bus viewer: a write is latched when wr rises while cs is still low.
  always @(negedge clk) begin
    if (wr_prev === 1'b0 && lcd_wr_o === 1'b1 && lcd_cs_o === 1'b0)
      cap_q.push_back({lcd_dc_o, lcd_data_o});
    wr_prev <= lcd_wr_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op and check every cycle of it against the phase timeline.
  // With hold set, req_valid stays high (as a data write of 0x77) after accept.
  task automatic do_op(input logic [1:0] op, input logic [7:0] d,
                       input logic [7:0] rdv, input bit hold);
    int t, low, total;
    bit is_wr, is_rd;
    t = 0;
    while (req_ready !== 1'b1 && t < 300) begin @(negedge clk); t++; end
    chk("accept_wait", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_data = d;
    @(negedge clk);
    if (hold) begin
      req_op = OP_WR_DATA; req_data = 8'h77;
    end else begin
      req_valid = 1'b0; req_data = 8'($urandom);
    end
    is_wr = (op == OP_WR_CMD || op == OP_WR_DATA);
    is_rd = (op == OP_RD_DATA);
    low   = is_rd ? RL : WL;
    total = (op == OP_HW_RESET) ? RC + RW : S + low + H;
    if (is_wr) exp_q.push_back({op[0], d});
    for (int k = 1; k <= total + 1; k++) begin
      lcd_data_i = (k >= S + 1 && k <= S + low) ? rdv : ~rdv;
      chk($sformatf("cs@%0d op%0d", k, op), lcd_cs_o, (op != OP_HW_RESET && k <= total) ? 0 : 1);
      chk($sformatf("wr@%0d op%0d", k, op), lcd_wr_o, (is_wr && k > S && k <= S + WL) ? 0 : 1);
      chk($sformatf("rd@%0d op%0d", k, op), lcd_rd_o, (is_rd && k > S && k <= S + RL) ? 0 : 1);
      chk($sformatf("oe@%0d op%0d", k, op), lcd_data_oe, (is_wr && k <= total) ? 1 : 0);
      chk($sformatf("ready@%0d op%0d", k, op), req_ready, (k > total) ? 1 : 0);
      chk($sformatf("busy@%0d op%0d", k, op), busy, (k > total) ? 0 : 1);
      chk($sformatf("lcdrst@%0d op%0d", k, op), lcd_reset_o, (op == OP_HW_RESET && k <= RC) ? 0 : 1);
      chk($sformatf("rspv@%0d op%0d", k, op), rsp_valid, (is_rd && k == S + RL + 1) ? 1 : 0);
      if (is_wr && k <= total) begin
        chk($sformatf("data@%0d", k), lcd_data_o, d);
        chk($sformatf("dc@%0d", k), lcd_dc_o, op[0]);
      end
      if (is_rd && k <= total) chk($sformatf("rd_dc@%0d", k), lcd_dc_o, 1);
      if (is_rd && k > S + RL) chk($sformatf("rspd@%0d", k), rsp_data, rdv);
      if (k <= total) @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, wr_low_n;
    logic [7:0] m_seen;
    logic [1:0] rop;
    nreset = 1'b0; req_valid = 1'b0; req_op = '0; req_data = '0; lcd_data_i = '0;
    m_req_valid = 1'b0; m_req_op = '0; m_req_data = '0; m_data_i = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_lcdrst", lcd_reset_o, 1);
    chk("rst_cs", lcd_cs_o, 1);
    chk("rst_dc", lcd_dc_o, 1);
    chk("rst_wr", lcd_wr_o, 1);
    chk("rst_rd", lcd_rd_o, 1);
    chk("rst_data", lcd_data_o, 0);
    chk("rst_oe", lcd_data_oe, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_data, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 1);
    nreset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // Command write, then data write back-to-back (one idle cs-high cycle)
    do_op(OP_WR_CMD, 8'h2A, 8'h00, 1'b0);
    do_op(OP_WR_DATA, 8'hC3, 8'h00, 1'b0);

    // Read of 0x5E; response holds afterwards
    do_op(OP_RD_DATA, 8'h00, 8'h5E, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("rspd_hold", rsp_data, 8'h5E);
      chk("rspv_idle", rsp_valid, 0);
    end

    // Hardware reset with req_valid held; the held write follows on time
    do_op(OP_HW_RESET, 8'h00, 8'h00, 1'b1);
    do_op(OP_WR_DATA, 8'h77, 8'h00, 1'b0);

    // Reset during the write strobe drops the cycle
    req_valid = 1'b1; req_op = OP_WR_CMD; req_data = 8'hE7;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_pre_wr", lcd_wr_o, 0);
    nreset = 1'b0;
    @(negedge clk);
    chk("abort_wr", lcd_wr_o, 1);
    chk("abort_cs", lcd_cs_o, 1);
    chk("abort_oe", lcd_data_oe, 0);
    chk("abort_rspv", rsp_valid, 0);
    chk("abort_ready", req_ready, 0);
    nreset = 1'b1;
    @(negedge clk);
    chk("abort_ready_back", req_ready, 1);
    chk("abort_rspv2", rsp_valid, 0);
    do_op(OP_WR_CMD, 8'hE7, 8'h00, 1'b0);

    // Random ops
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 2));
      do_op(rop, 8'($urandom), 8'($urandom), 1'b0);
    end

    // Minimum timing: 3 busy cycles, wr low exactly 1
    chk("min_ready0", m_req_ready, 1);
    m_req_valid = 1'b1; m_req_op = OP_WR_DATA; m_req_data = 8'h96;
    @(negedge clk);
    m_req_valid = 1'b0; m_req_data = 8'h00;
    busy_n = 0; wr_low_n = 0; m_seen = 8'h00;
    for (int k = 1; k <= 6; k++) begin
      if (m_req_ready !== 1'b1) busy_n++;
      if (m_wr === 1'b0) begin wr_low_n++; m_seen = m_data_o; end
      @(negedge clk);
    end
    chk("min_busy_cycles", busy_n, 3);
    chk("min_wr_low", wr_low_n, 1);
    chk("min_wr_data", m_seen, 8'h96);
    chk("min_ready_end", m_req_ready, 1);

    // Viewer contents
    chk("viewer_count", cap_q.size(), exp_q.size());
    for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
      chk($sformatf("viewer[%0d]", i), cap_q[i], exp_q[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/lcd8080_bus_master.md
Name: lcd8080_bus_master

Overview:
- Initiator side of the 8-bit 8080-style parallel display bus: reset, cs, dc, wr, rd and data[7:0].
- Takes byte-level requests from a local valid/ready port.
- Generates correctly timed bus cycles: command write, data write, data read and hardware reset pulse.
- Sits between a display-driver sequencer and the panel pins; its bus outputs are what the parallel bus viewer captures on wr rising edges.

Parameters:
- SETUP_CYCLES, 1, clocks with cs low and dc/data valid before the strobe falls (min 1)
- WR_LOW_CYCLES, 2, wr low width in clocks (min 1)
- RD_LOW_CYCLES, 4, rd low width in clocks (min 1)
- HIGH_CYCLES, 2, strobe high time with cs still low, closing each cycle (min 1)
- RESET_CYCLES, 16, lcd_reset_o low width for a hardware reset op (min 1)
- RESET_WAIT_CYCLES, 64, wait after lcd_reset_o rises before accepting the next request (min 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- nreset  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request; high only in IDLE
- req_op  in  2  00 write command, 01 write data, 10 read data, 11 hardware reset
- req_data  in  8  byte to write; ignored for ops 10/11
- rsp_valid  out  1  one-cycle pulse, read byte available
- rsp_data  out  8  last byte read; holds value until next read
- busy  out  1  equals not req_ready
- lcd_reset_o  out  1  panel reset, active low
- lcd_cs_o  out  1  chip select, active low
- lcd_dc_o  out  1  0 = command, 1 = data
- lcd_wr_o  out  1  write strobe, active low; panel latches on rising edge
- lcd_rd_o  out  1  read strobe, active low
- lcd_data_o  out  8  bus drive value
- lcd_data_oe  out  1  pad output enable, 1 = drive lcd_data_o
- lcd_data_i  in  8  bus value from pad

Behaviour:
- Clocking and reset: one clock (clk). Reset is synchronous and active-low (nreset).
- Reset values (nreset low at a clk edge):
  - lcd_reset_o=1, lcd_cs_o=1, lcd_dc_o=1, lcd_wr_o=1, lcd_rd_o=1
  - lcd_data_o=0, lcd_data_oe=0, rsp_valid=0, rsp_data=0, req_ready=0
  - state=IDLE, counter=0; req_ready becomes 1 in the first cycle after nreset is released.
- Reset mid-operation: bus returns to idle levels at the same edge; the request is dropped and no rsp_valid is issued.
- All bus outputs are registered; no combinational path from request inputs to lcd_* pins.
- Handshake: accept when req_valid && req_ready at an edge E0. Inputs are captured at E0; req_data may change afterwards.
- States: IDLE, SETUP, STROBE, HIGH, RST_LOW, RST_WAIT. A single down-counter is loaded on each entry with (param-1); the state exits when the counter is 0.
- Ops 00/01/10, after E0:
  - SETUP: cs=0; dc=req_op[0] for writes, dc=1 for reads. Writes: data_o=req_data, oe=1. Reads: oe=0.
  - STROBE: writes wr=0 for WR_LOW_CYCLES; reads rd=0 for RD_LOW_CYCLES.
  - HIGH: wr=1, rd=1, cs still 0, data/oe held, for HIGH_CYCLES.
  - Then IDLE: cs=1, oe=0, req_ready=1.
- Occupancy: req_ready is low for exactly SETUP+LOW+HIGH cycles.
- Back-to-back requests: cs is high for at least one IDLE cycle between bus cycles.
- Read sampling: lcd_data_i is sampled into rsp_data at the edge leaving STROBE. rsp_valid=1 for exactly the first HIGH cycle.
- Write data: lcd_data_o is stable from SETUP through HIGH, so it is valid at the wr rising edge with HIGH_CYCLES of hold.
- Op 11:
  - RST_LOW: lcd_reset_o=0 for RESET_CYCLES; cs/wr/rd stay high.
  - RST_WAIT: lcd_reset_o=1 for RESET_WAIT_CYCLES.
  - Then IDLE.
- Counter width: $clog2 of the largest parameter plus 1. Out-of-range parameters (<1) are rejected by an elaboration check.
- req_valid while busy is ignored; the requester holds it until accepted.

Decomposition:
- Package lcd8080_pkg holds:
  - op encodings OP_WR_CMD=2'b00, OP_WR_DATA=2'b01, OP_RD_DATA=2'b10, OP_HW_RESET=2'b11
  - the state enum
- No sub-module; a single FSM plus one down-counter.
- Pad tristate lives at the top level, built from lcd_data_o/lcd_data_oe.

Test Plan:
- Defaults, op 00, data 0x2A accepted at cycle 0:
  - cs low cycles 1-5, dc=0, wr low cycles 2-3, data=0x2A and oe=1 cycles 1-5
  - req_ready back at cycle 6; a viewer model captures 0x2A, dc=0.
- Op 01 data 0xC3 issued immediately after an op 00: cs high for exactly one cycle between the two bus cycles; dc=1 on the second.
- Op 10 with lcd_data_i=0x5E only during rd-low: rd low 4 cycles, oe=0 throughout, rsp_valid one pulse, rsp_data=0x5E and held afterwards.
- Op 11: lcd_reset_o low exactly 16 cycles, req_ready low for 80 cycles total; req_valid held high meanwhile is not accepted early.
- nreset asserted mid-STROBE of a write: next cycle wr=1, cs=1, oe=0, state IDLE; no rsp_valid. The same request re-issued after release completes normally.
- SETUP=1/WR_LOW=1/HIGH=1: minimum write occupies 3 cycles, with wr low exactly 1 cycle.
